// File: rtl/video_pkg.sv
// Shared types and constants for the stream-to-framebuffer writer.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RETRY
    } wr_state_e;

    localparam logic [2:0] WSHB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WSHB_BTE_LINEAR  = 2'b00;

    function automatic int frame_words(input int hdisp, input int vdisp);
        return hdisp * vdisp;
    endfunction

endpackage

// File: rtl/fb_addr_cnt.sv
// Wrapping pixel index counter: clears on start-of-frame, advances per completed
// write and flags the last pixel of the frame.
module fb_addr_cnt
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    localparam int FRAME = frame_words(HDISP, VDISP),
    localparam int IDX_W = (FRAME > 1) ? $clog2(FRAME) : 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME - 1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign last = (idx_q == LAST_IDX);
    assign idx  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/stream_fb_writer.sv
// Wishbone master writing a valid/ready pixel stream into a linear framebuffer.
// Define FB_DOUBLE_BUFFER_EN to ping-pong between two framebuffers.
module stream_fb_writer
    import video_pkg::*;
#(
    parameter int          HDISP   = 800,
    parameter int          VDISP   = 480,
    parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [31:0] pix_data,
    input  logic        pix_sof,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    input  logic        wshb_err,
    input  logic        wshb_rty,
    output logic        frame_done,
    output logic [15:0] err_cnt,
    output logic        fb_sel
);

    localparam int FRAME = frame_words(HDISP, VDISP);
    localparam int IDX_W = (FRAME > 1) ? $clog2(FRAME) : 1;

    wr_state_e        state_q, state_d;
    logic             bus_q, bus_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             done_q, done_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic             cnt_clr, cnt_inc;
    logic [IDX_W-1:0] pix_idx;
    logic [IDX_W-1:0] eff_idx;
    logic             pix_last;
    logic [31:0]      base;

    // While a write is outstanding the counter holds the index being written,
    // so its last flag directly qualifies frame completion.
    fb_addr_cnt #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_cnt (
        .clk  (sys_clk),
        .srst (sys_rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .idx  (pix_idx),
        .last (pix_last)
    );

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic [31:0] ALT_OFS = 32'(4 * FRAME);

    logic fb_sel_q, fb_sel_d;

    // Write into the buffer the reader is not showing.
    assign base   = fb_sel_q ? FB_BASE : FB_BASE + ALT_OFS;
    assign fb_sel = fb_sel_q;

    always_comb begin
        fb_sel_d = done_d ? ~fb_sel_q : fb_sel_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fb_sel_q <= 1'b0;
        end else begin
            fb_sel_q <= fb_sel_d;
        end
    end
`else
    assign base   = FB_BASE;
    assign fb_sel = 1'b0;
`endif

    assign eff_idx = pix_sof ? '0 : pix_idx;

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        done_d    = 1'b0;
        err_cnt_d = err_cnt_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid) begin
                    dat_d   = pix_data;
                    adr_d   = base + (32'(eff_idx) << 2);
                    cnt_clr = pix_sof;
                    bus_d   = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // An errored pixel is dropped but still consumes its index.
                if (wshb_err || wshb_ack) begin
                    bus_d   = 1'b0;
                    cnt_inc = 1'b1;
                    done_d  = pix_last;
                    state_d = IDLE;
                    if (wshb_err && err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end else if (wshb_rty) begin
                    bus_d   = 1'b0;
                    state_d = RETRY;
                end
            end
            RETRY: begin
                bus_d   = 1'b1;
                state_d = WRITE;
            end
            default: begin
                bus_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            bus_q     <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pix_ready   = (state_q == IDLE) && !sys_rst;
    assign wshb_cyc    = bus_q;
    assign wshb_stb    = bus_q;
    assign wshb_we     = bus_q;
    assign wshb_adr    = adr_q;
    assign wshb_dat_ms = dat_q;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = WSHB_CTI_CLASSIC;
    assign wshb_bte    = WSHB_BTE_LINEAR;
    assign frame_done  = done_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_stream_fb_writer.sv
// Self-checking bench for stream_fb_writer (4x2 frame), directed plus random traffic.
module tb_stream_fb_writer;

    localparam int FRAME = 8;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [31:0] pix_data = '0;
    logic        pix_sof = 1'b0;
    logic        wshb_cyc, wshb_stb, wshb_we;
    logic [31:0] wshb_adr, wshb_dat_ms;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic        wshb_ack = 1'b0, wshb_err = 1'b0, wshb_rty = 1'b0;
    logic        frame_done;
    logic [15:0] err_cnt;
    logic        fb_sel;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          exp_idx = 0;
    int          exp_errs = 0;
    logic        exp_fbsel = 1'b0;

    stream_fb_writer #(
        .HDISP   (4),
        .VDISP   (2),
        .FB_BASE (32'h0000_0000)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .wshb_cyc    (wshb_cyc),
        .wshb_stb    (wshb_stb),
        .wshb_we     (wshb_we),
        .wshb_adr    (wshb_adr),
        .wshb_dat_ms (wshb_dat_ms),
        .wshb_sel    (wshb_sel),
        .wshb_cti    (wshb_cti),
        .wshb_bte    (wshb_bte),
        .wshb_ack    (wshb_ack),
        .wshb_err    (wshb_err),
        .wshb_rty    (wshb_rty),
        .frame_done  (frame_done),
        .err_cnt     (err_cnt),
        .fb_sel      (fb_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] exp_base();
`ifdef FB_DOUBLE_BUFFER_EN
        return exp_fbsel ? 32'h0000_0000 : 32'h0000_0020;
`else
        return 32'h0000_0000;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (pix_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'b0, pix_ready}, 32'd1);
    endtask

    task automatic check_bus(input string tag, input logic [31:0] adr_e, input logic [31:0] dat_e);
        chk({tag, "_cyc_stb_we"}, {29'b0, wshb_cyc, wshb_stb, wshb_we}, 32'd7);
        chk({tag, "_adr"}, wshb_adr, adr_e);
        chk({tag, "_dat"}, wshb_dat_ms, dat_e);
        chk({tag, "_ready_low"}, {31'b0, pix_ready}, 32'd0);
    endtask

    // resp: 0 ack, 1 err, 2 rty then ack, 3 err+ack, 4 ack+rty, 5 err+ack+rty
    task automatic send(input logic [31:0] d, input logic sof, input int resp, input int dly);
        int          eff;
        logic [31:0] adr_e;
        logic        is_err;
        logic        done_e;
        wait_ready();
        eff   = sof ? 0 : exp_idx;
        adr_e = exp_base() + 32'(4 * eff);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = $urandom;
        check_bus("issue", adr_e, d);
        for (int i = 0; i < dly; i++) begin
            tick();
            check_bus("hold", adr_e, d);
        end
        if (resp == 2) begin
            wshb_rty = 1'b1;
            tick();
            wshb_rty = 1'b0;
            chk("rty_gap_cyc", {30'b0, wshb_cyc, wshb_stb}, 32'd0);
            chk("rty_gap_ready", {31'b0, pix_ready}, 32'd0);
            tick();
            check_bus("reissue", adr_e, d);
        end
        is_err   = (resp == 1) || (resp == 3) || (resp == 5);
        wshb_ack = (resp != 1);
        wshb_err = is_err;
        wshb_rty = (resp == 4) || (resp == 5);
        tick();
        wshb_ack = 1'b0;
        wshb_err = 1'b0;
        wshb_rty = 1'b0;
        done_e  = (eff == FRAME - 1);
        exp_idx = (eff + 1) % FRAME;
        if (is_err && exp_errs < 16'hFFFF) exp_errs++;
`ifdef FB_DOUBLE_BUFFER_EN
        if (done_e) exp_fbsel = ~exp_fbsel;
`endif
        chk("done_cyc", {30'b0, wshb_cyc, wshb_stb}, 32'd0);
        chk("frame_done", {31'b0, frame_done}, {31'b0, done_e});
        chk("err_cnt", {16'b0, err_cnt}, 32'(exp_errs));
        chk("fb_sel", {31'b0, fb_sel}, {31'b0, exp_fbsel});
        chk("ready_back", {31'b0, pix_ready}, 32'd1);
        $display("px dat=%08h sof=%0d resp=%0d dly=%0d adr=%08h frame_done=%0d err_cnt=%0d",
                 d, sof, resp, dly, adr_e, frame_done, err_cnt);
        tick();
        chk("frame_done_pulse", {31'b0, frame_done}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          r;

        // Reset state
        repeat (3) tick();
        chk("rst_cyc_stb_we", {29'b0, wshb_cyc, wshb_stb, wshb_we}, 32'd0);
        chk("rst_adr", wshb_adr, 32'd0);
        chk("rst_dat", wshb_dat_ms, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        chk("rst_fb_sel", {31'b0, fb_sel}, 32'd0);
        chk("rst_ready", {31'b0, pix_ready}, 32'd0);
        chk("const_sel", {28'b0, wshb_sel}, 32'hF);
        chk("const_cti", {29'b0, wshb_cti}, 32'd0);
        chk("const_bte", {30'b0, wshb_bte}, 32'd0);
        sys_rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, pix_ready}, 32'd1);

        // Full frame, then wrap
        for (int i = 0; i < 8; i++) send(32'hA0 + 32'(i), (i == 0), 0, 1);
        send(32'hB0, 1'b0, 0, 0);

        // Mid-frame resync
        send(32'hB1, 1'b0, 0, 0);
        send(32'hB2, 1'b0, 0, 0);
        send(32'hB3, 1'b1, 0, 0);
        send(32'hB4, 1'b0, 0, 0);

        // Error, retry, backpressure
        send(32'hC0, 1'b1, 0, 0);
        send(32'hC1, 1'b0, 1, 0);
        send(32'hC2, 1'b0, 0, 0);
        send(32'hC3, 1'b0, 2, 1);
        send(32'hC4, 1'b0, 0, 5);

        // Random traffic including coinciding responses
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            rd = $urandom;
            send(rd, ($urandom_range(0, 7) == 0), (r < 5) ? 0 : r - 4, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a write
        wait_ready();
        pix_valid = 1'b1;
        pix_data  = 32'hD0;
        pix_sof   = 1'b0;
        tick();
        pix_valid = 1'b0;
        chk("midrst_stb", {31'b0, wshb_stb}, 32'd1);
        sys_rst = 1'b1;
        tick();
        chk("midrst_cyc_stb", {30'b0, wshb_cyc, wshb_stb}, 32'd0);
        chk("midrst_fb_sel", {31'b0, fb_sel}, 32'd0);
        chk("midrst_err_cnt", {16'b0, err_cnt}, 32'd0);
        chk("midrst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("midrst_ready", {31'b0, pix_ready}, 32'd0);
        sys_rst   = 1'b0;
        exp_idx   = 0;
        exp_errs  = 0;
        exp_fbsel = 1'b0;
        send(32'hD1, 1'b0, 0, 0);
        send(32'hD2, 1'b0, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_fb_writer.md
Name: stream_fb_writer

Overview:
- Wishbone master in the sys_clk domain, sitting directly upstream of the Wishbone interconnect.
- Accepts a valid/ready pixel stream (one 32-bit pixel per transfer) and writes it into the SDRAM framebuffer that the VGA reader scans.
- Generates linear framebuffer addresses, wraps at end of frame, resynchronises on start-of-frame and reports frame completion.

Parameters:
- HDISP, 800, displayed pixels per line.
- VDISP, 480, displayed lines per frame.
- FB_BASE, 32'h0000_0000, byte address of framebuffer 0.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  stream pixel valid.
- pix_ready  out  1  block can accept a pixel.
- pix_data  in  32  pixel word, written unchanged.
- pix_sof  in  1  qualifies pix_data as pixel (0,0) of a frame.
- wshb_cyc, wshb_stb, wshb_we  out  1 each  Wishbone master controls.
- wshb_adr  out  32  byte address.
- wshb_dat_ms  out  32  write data.
- wshb_sel  out  4  byte enables.
- wshb_cti  out  3  cycle type.
- wshb_bte  out  2  burst type.
- wshb_ack, wshb_err, wshb_rty  in  1 each  slave responses.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is acknowledged.
- err_cnt  out  16  count of Wishbone errors; saturating.
- fb_sel  out  1  framebuffer in use; see Optional Feature.

Behaviour:
- Interface: one clock (sys_clk); reset is synchronous and active-high (sys_rst).
- FSM states IDLE and WRITE. Reset goes to IDLE with:
  - pix_idx=0.
  - wshb_cyc/stb/we=0; wshb_adr=0; wshb_dat_ms=0.
  - frame_done=0; err_cnt=0; fb_sel=0.
- Constant outputs: wshb_sel=4'hF, wshb_cti=3'b000 (classic), wshb_bte=2'b00.
- pix_ready=1 exactly when state==IDLE and sys_rst=0.
- IDLE:
  - On pix_valid&&pix_ready the block registers pix_data into wshb_dat_ms.
  - The effective index is 0 if pix_sof=1, else pix_idx.
  - wshb_adr is set to base + 4*effective index, with base = FB_BASE, or the alternate base when the double buffer is enabled.
  - wshb_cyc=stb=we=1 from the next cycle; state goes to WRITE.
- WRITE:
  - cyc/stb/we and adr/dat_ms are held stable until a response arrives.
  - Priority when responses coincide: err > ack > rty.
  - ack: drop cyc/stb/we the same edge; pix_idx = effective index+1, wrapping to 0 after HDISP*VDISP-1. If the written index was HDISP*VDISP-1, frame_done pulses for 1 cycle. Return to IDLE.
  - err: drop cycle; err_cnt+1, saturating at 16'hFFFF; pixel dropped but pix_idx still advances, so the frame stays aligned; frame_done rules as for ack. Return to IDLE.
  - rty: drop cycle for exactly one cycle (state RETRY), then reissue the identical write; pix_ready stays 0.
- Throughput: at most one pixel per 2 cycles plus slave latency. Minimum latency is 1 cycle from accept to stb.
- pix_sof on a pixel whose index is already 0 has no side effect. Mid-frame pix_sof restarts at 0 without a frame_done pulse.
- Width rules:
  - pix_idx width is $clog2(HDISP*VDISP).
  - Address arithmetic is 32-bit and unsigned; the overflow wraps silently.
- Reset mid-WRITE: cyc/stb drop on the next edge, with no completion recorded.

Optional Feature:
- Macro FB_DOUBLE_BUFFER_EN.
- When defined:
  - Second framebuffer at FB_BASE + 4*HDISP*VDISP.
  - Writes target buffer ~fb_sel.
  - fb_sel toggles on the same edge that frame_done pulses, so the VGA reader shows the finished frame.
- When undefined: all writes use FB_BASE and fb_sel is tied to 0.

Decomposition:
- Package video_pkg holds:
  - the FSM state enum (IDLE, WRITE, RETRY);
  - WSHB_CTI_CLASSIC=3'b000, WSHB_BTE_LINEAR=2'b00;
  - a constant function frame_words(HDISP,VDISP).
- One sub-module: fb_addr_cnt, the wrapping pixel index counter with a sof clear and a last-pixel flag.

Test Plan:
- Frame write (HDISP=4, VDISP=2, FB_BASE=0, ack 1 cycle after stb):
  - Stimulus: 8 pixels 32'hA0..A7, sof on the first.
  - Response: writes to addresses 0x00..0x1C in order with matching data; frame_done pulses once after the 8th ack.
- Wrap: a 9th pixel 32'hB0 without sof is written to address 0x00.
- Mid-frame resync: after 3 pixels, send a pixel with sof=1. Response: address 0x00, no frame_done, and the next pixel goes to 0x04.
- Error and retry:
  - err on the 2nd write: err_cnt=1, no reissue, 3rd pixel at 0x08.
  - rty on a write: one idle cycle, then an identical adr/dat reissue; pix_ready stays 0 throughout.
- Backpressure: ack delayed 5 cycles. Response: pix_ready=0 and adr/dat stable for all 5 cycles, and no pixel is lost.
- FB_DOUBLE_BUFFER_EN:
  - First frame goes to 0x20..0x3C with fb_sel=0.
  - fb_sel=1 after frame_done; the second frame goes to 0x00..0x1C.
  - sys_rst mid-WRITE returns fb_sel=0 and cyc=0.
